// File: rtl/ifu_pc_ctrl.sv
// Fetch-PC controller: sequences IDLE/BOOT/RUN/HALT, owns the fetch PC and
// issues fetch requests, applying halts, exception traps and redirects.
module ifu_pc_ctrl #(
  parameter int PC_WIDTH = 32,
  parameter int EXC_NUM  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sync_start_pulse,
  input  logic [PC_WIDTH-1:0] sync_start_pc,
  input  logic [EXC_NUM-1:0]  sync_core_configuration,
  input  logic                halt_req,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                exception_valid,
  input  logic [EXC_NUM-1:0]  exception_id,
  input  logic [PC_WIDTH-1:0] trap_vector,
  output logic                fetch_req_valid,
  output logic [PC_WIDTH-1:0] fetch_req_pc,
  input  logic                fetch_req_ready,
  output logic                core_running,
  output logic                core_halted,
  output logic                misalign_err,
  output logic [EXC_NUM-1:0]  cfg_latched
);

  typedef enum logic [1:0] {IDLE, BOOT, RUN, HALT} state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic                trap_hit;
  logic                stop_run;
  logic [PC_WIDTH-1:0] target;

  // An exception outranks a redirect, so its vector is the target when both fire.
  assign trap_hit = |(exception_id & cfg_latched);
  assign stop_run = halt_req || (exception_valid && !trap_hit);
  assign target   = exception_valid ? trap_vector : redirect_pc;

  assign fetch_req_pc = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      pc              <= '0;
      fetch_req_valid <= 1'b0;
      core_running    <= 1'b0;
      core_halted     <= 1'b0;
      misalign_err    <= 1'b0;
      cfg_latched     <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (sync_start_pulse) begin
            pc          <= sync_start_pc;
            cfg_latched <= sync_core_configuration;
            if (sync_start_pc[1:0] != 2'b00) begin
              state        <= HALT;
              misalign_err <= 1'b1;
              core_halted  <= 1'b1;
            end else begin
              state        <= BOOT;
              misalign_err <= 1'b0;
              core_halted  <= 1'b0;
            end
          end
        end
        BOOT: begin
          state           <= RUN;
          fetch_req_valid <= 1'b1;
          core_running    <= 1'b1;
        end
        RUN: begin
          if (stop_run) begin
            state           <= HALT;
            fetch_req_valid <= 1'b0;
            core_running    <= 1'b0;
            core_halted     <= 1'b1;
          end else if (exception_valid || redirect_valid) begin
            // Any fetch accepted this cycle is squashed by the new target.
            pc <= target;
            if (target[1:0] != 2'b00) begin
              state           <= HALT;
              fetch_req_valid <= 1'b0;
              core_running    <= 1'b0;
              core_halted     <= 1'b1;
              misalign_err    <= 1'b1;
            end
          end else if (fetch_req_ready) begin
            pc <= pc + PC_WIDTH'(4);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_pc_ctrl.sv
// Self-checking bench for ifu_pc_ctrl: directed scenarios plus randomized
// stimulus compared against a behavioural model of the fetch controller.
module tb_ifu_pc_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sync_start_pulse;
  logic [31:0] sync_start_pc;
  logic [3:0]  sync_core_configuration;
  logic        halt_req;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exception_valid;
  logic [3:0]  exception_id;
  logic [31:0] trap_vector;
  logic        fetch_req_valid;
  logic [31:0] fetch_req_pc;
  logic        fetch_req_ready;
  logic        core_running;
  logic        core_halted;
  logic        misalign_err;
  logic [3:0]  cfg_latched;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model: mode is one of "idle", "boot", "run", "halt".
  string       m_mode = "idle";
  logic [31:0] m_pc   = '0;
  logic [3:0]  m_cfg  = '0;
  logic        m_mis  = 1'b0;

  always #5 clk = ~clk;

  ifu_pc_ctrl #(.PC_WIDTH(32), .EXC_NUM(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .sync_start_pulse(sync_start_pulse), .sync_start_pc(sync_start_pc),
    .sync_core_configuration(sync_core_configuration),
    .halt_req(halt_req), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exception_valid(exception_valid), .exception_id(exception_id),
    .trap_vector(trap_vector),
    .fetch_req_valid(fetch_req_valid), .fetch_req_pc(fetch_req_pc),
    .fetch_req_ready(fetch_req_ready),
    .core_running(core_running), .core_halted(core_halted),
    .misalign_err(misalign_err), .cfg_latched(cfg_latched)
  );

  // Apply the spec's rules to the inputs present at the coming edge.
  task automatic model_update();
    logic [31:0] tgt;
    bit          jump;
    if (!rst_n) begin
      m_mode = "idle"; m_pc = '0; m_cfg = '0; m_mis = 1'b0;
    end else if (m_mode == "idle" || m_mode == "halt") begin
      if (sync_start_pulse) begin
        m_pc  = sync_start_pc;
        m_cfg = sync_core_configuration;
        m_mis = (sync_start_pc % 4) != 0;
        m_mode = m_mis ? "halt" : "boot";
      end
    end else if (m_mode == "boot") begin
      m_mode = "run";
    end else begin
      jump = 1'b0;
      tgt  = '0;
      if (halt_req) m_mode = "halt";
      else if (exception_valid) begin
        if ((exception_id & m_cfg) != 0) begin jump = 1'b1; tgt = trap_vector; end
        else m_mode = "halt";
      end else if (redirect_valid) begin jump = 1'b1; tgt = redirect_pc; end
      else if (fetch_req_ready) m_pc = m_pc + 32'd4;
      if (jump) begin
        m_pc = tgt;
        if (tgt % 4 != 0) begin m_mode = "halt"; m_mis = 1'b1; end
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sync_start_pulse = 0; sync_start_pc = '0; sync_core_configuration = '0;
    halt_req = 0; redirect_valid = 0; redirect_pc = '0;
    exception_valid = 0; exception_id = '0; trap_vector = '0;
    fetch_req_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    repeat (3) step();
    rst_n = 1;
    vectors++; if (fetch_req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", fetch_req_valid); end
    vectors++; if (fetch_req_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", fetch_req_pc); end
    vectors++; if ({core_running, core_halted, misalign_err} !== 3'b000) begin errors++; $display("FAIL reset_status got %b exp 000", {core_running, core_halted, misalign_err}); end
    vectors++; if (cfg_latched !== 4'h0) begin errors++; $display("FAIL reset_cfg got %h exp 0", cfg_latched); end
  endtask

  task automatic test_boot();
    sync_start_pulse = 1; sync_start_pc = 32'h1000; sync_core_configuration = 4'b0010;
    fetch_req_ready = 1;
    step();
    sync_start_pulse = 0; sync_start_pc = '0; sync_core_configuration = '0;
    vectors++; if ({fetch_req_valid, core_running} !== 2'b00) begin errors++; $display("FAIL boot_t1 got %b exp 00", {fetch_req_valid, core_running}); end
    vectors++; if (cfg_latched !== 4'b0010) begin errors++; $display("FAIL boot_cfg got %h exp 2", cfg_latched); end
    step();
    vectors++; if ({fetch_req_valid, core_running} !== 2'b11) begin errors++; $display("FAIL boot_t2 got %b exp 11", {fetch_req_valid, core_running}); end
    vectors++; if (fetch_req_pc !== 32'h1000) begin errors++; $display("FAIL boot_pc0 got %h exp 1000", fetch_req_pc); end
    step();
    vectors++; if (fetch_req_pc !== 32'h1004) begin errors++; $display("FAIL boot_pc1 got %h exp 1004", fetch_req_pc); end
    step();
    vectors++; if (fetch_req_pc !== 32'h1008) begin errors++; $display("FAIL boot_pc2 got %h exp 1008", fetch_req_pc); end
  endtask

  task automatic test_backpressure();
    fetch_req_ready = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++; if ({fetch_req_valid, fetch_req_pc} !== {1'b1, 32'h1008}) begin errors++; $display("FAIL bp_hold%0d got %b/%h exp 1/1008", i, fetch_req_valid, fetch_req_pc); end
    end
    fetch_req_ready = 1;
    step();
    vectors++; if (fetch_req_pc !== 32'h100C) begin errors++; $display("FAIL bp_release got %h exp 100c", fetch_req_pc); end
  endtask

  task automatic test_priority();
    redirect_valid = 1; redirect_pc = 32'h2000;
    exception_valid = 1; exception_id = 4'b0010; trap_vector = 32'h0100;
    fetch_req_ready = 1;
    step();
    vectors++; if ({fetch_req_valid, fetch_req_pc} !== {1'b1, 32'h0100}) begin errors++; $display("FAIL prio_trap got %b/%h exp 1/0100", fetch_req_valid, fetch_req_pc); end
    redirect_valid = 0; exception_valid = 0;
    halt_req = 1;
    step();
    halt_req = 0;
    vectors++; if ({fetch_req_valid, core_halted, core_running} !== 3'b010) begin errors++; $display("FAIL prio_halt got %b exp 010", {fetch_req_valid, core_halted, core_running}); end
    sync_start_pulse = 1; sync_start_pc = 32'h1000; sync_core_configuration = 4'b0000;
    step();
    sync_start_pulse = 0;
    step();
    redirect_valid = 1; exception_valid = 1;
    step();
    redirect_valid = 0; exception_valid = 0;
    vectors++; if ({fetch_req_valid, core_halted} !== 2'b01) begin errors++; $display("FAIL prio_nocfg got %b exp 01", {fetch_req_valid, core_halted}); end
    vectors++; if (fetch_req_pc !== 32'h1000) begin errors++; $display("FAIL prio_nocfg_pc got %h exp 1000", fetch_req_pc); end
  endtask

  task automatic test_misalign();
    sync_start_pulse = 1; sync_start_pc = 32'h1002; sync_core_configuration = 4'hF;
    step();
    sync_start_pulse = 0;
    vectors++; if ({core_halted, misalign_err, fetch_req_valid} !== 3'b110) begin errors++; $display("FAIL mis_start got %b exp 110", {core_halted, misalign_err, fetch_req_valid}); end
    vectors++; if (fetch_req_pc !== 32'h1002) begin errors++; $display("FAIL mis_pc got %h exp 1002", fetch_req_pc); end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (fetch_req_valid !== 1'b0) begin errors++; $display("FAIL mis_novalid%0d got %b exp 0", i, fetch_req_valid); end
    end
    sync_start_pulse = 1; sync_start_pc = 32'h1000;
    step();
    sync_start_pulse = 0;
    vectors++; if ({misalign_err, core_halted} !== 2'b00) begin errors++; $display("FAIL mis_clear got %b exp 00", {misalign_err, core_halted}); end
    step();
    vectors++; if ({fetch_req_valid, fetch_req_pc} !== {1'b1, 32'h1000}) begin errors++; $display("FAIL mis_restart got %b/%h exp 1/1000", fetch_req_valid, fetch_req_pc); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; fetch_req_ready = 1;
    step();
    redirect_valid = 0;
    vectors++; if (fetch_req_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top got %h exp fffffffc", fetch_req_pc); end
    step();
    vectors++; if ({fetch_req_valid, fetch_req_pc} !== {1'b1, 32'h0}) begin errors++; $display("FAIL wrap_zero got %b/%h exp 1/0", fetch_req_valid, fetch_req_pc); end
    redirect_valid = 1; redirect_pc = 32'h0000_3001;
    step();
    redirect_valid = 0;
    vectors++; if ({core_halted, misalign_err, fetch_req_pc} !== {2'b11, 32'h3001}) begin errors++; $display("FAIL redir_mis got %b%b/%h exp 11/3001", core_halted, misalign_err, fetch_req_pc); end
  endtask

  task automatic test_reset_mid_run();
    sync_start_pulse = 1; sync_start_pc = 32'h4000; sync_core_configuration = 4'h5;
    step();
    sync_start_pulse = 0;
    step();
    fetch_req_ready = 0;
    sync_start_pulse = 1; sync_start_pc = 32'h8000;
    step();
    sync_start_pulse = 0;
    vectors++; if ({core_running, fetch_req_valid, fetch_req_pc} !== {2'b11, 32'h4000}) begin errors++; $display("FAIL run_ignore_start got %b%b/%h exp 11/4000", core_running, fetch_req_valid, fetch_req_pc); end
    rst_n = 0;
    step();
    rst_n = 1;
    vectors++; if ({fetch_req_valid, core_running, core_halted, misalign_err, cfg_latched, fetch_req_pc} !== 40'h0) begin errors++; $display("FAIL mid_reset got %b%b%b%b/%h/%h exp all 0", fetch_req_valid, core_running, core_halted, misalign_err, cfg_latched, fetch_req_pc); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      idle_inputs();
      rst_n = ($urandom_range(0, 99) != 0);
      sync_start_pulse = ($urandom_range(0, 9) == 0);
      sync_start_pc = {$urandom_range(0, 65535), 16'h0} | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0) | 32'($urandom_range(0, 63) * 4);
      sync_core_configuration = 4'($urandom_range(0, 15));
      halt_req = ($urandom_range(0, 29) == 0);
      redirect_valid = ($urandom_range(0, 5) == 0);
      redirect_pc = $urandom() & (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      exception_valid = ($urandom_range(0, 9) == 0);
      exception_id = 4'b0001 << $urandom_range(0, 3);
      trap_vector = $urandom() & (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      fetch_req_ready = ($urandom_range(0, 2) != 0);
      step();
      vectors++; if (fetch_req_valid !== (m_mode == "run")) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, fetch_req_valid, m_mode == "run"); end
      vectors++; if (fetch_req_pc !== m_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h exp %h", i, fetch_req_pc, m_pc); end
      vectors++; if ({core_running, core_halted} !== {m_mode == "run", m_mode == "halt"}) begin errors++; $display("FAIL rnd_state cyc %0d got %b%b mode %s", i, core_running, core_halted, m_mode); end
      vectors++; if ({misalign_err, cfg_latched} !== {m_mis, m_cfg}) begin errors++; $display("FAIL rnd_flags cyc %0d got %b/%h exp %b/%h", i, misalign_err, cfg_latched, m_mis, m_cfg); end
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_backpressure();
    test_priority();
    test_misalign();
    test_wrap();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/ifu_pc_ctrl.md
# ifu_pc_ctrl

Fetch-PC controller in the IFU, directly downstream of the IFU start-signal synchronizer, in the CPU clock domain. Consumes the synchronized start pulse, start PC and core configuration. Sequences the core through boot, run and halt. Owns the architectural fetch PC and issues instruction-fetch requests over a valid/ready handshake, applying redirects (branch/jump) and exception traps.

## Interface
- PC_WIDTH, 32, width of PC and all addresses
- EXC_NUM, 4, number of exception sources; one config/enable bit each

- clk  in  1  CPU clock
- rst_n  in  1  reset, synchronous, active-low
- sync_start_pulse  in  1  synchronized single-cycle start request
- sync_start_pc  in  PC_WIDTH  boot PC; valid in the cycle sync_start_pulse=1
- sync_core_configuration  in  EXC_NUM  per-exception trap enable; valid in the cycle sync_start_pulse=1
- halt_req  in  1  core halt request, level
- redirect_valid  in  1  branch/jump redirect strobe
- redirect_pc  in  PC_WIDTH  redirect target
- exception_valid  in  1  exception strobe
- exception_id  in  EXC_NUM  one-hot exception source
- trap_vector  in  PC_WIDTH  trap handler address
- fetch_req_valid  out  1  fetch request valid
- fetch_req_pc  out  PC_WIDTH  fetch address
- fetch_req_ready  in  1  fetch port accepts
- core_running  out  1  state==RUN
- core_halted  out  1  state==HALT
- misalign_err  out  1  sticky misaligned-target error
- cfg_latched  out  EXC_NUM  configuration captured at start

## Operation
- States: IDLE (reset), BOOT, RUN, HALT. All outputs are registered.
- IDLE/HALT + sync_start_pulse:
  - Capture sync_start_pc and sync_core_configuration. Clear misalign_err. Go to BOOT.
  - If sync_start_pc[1:0]!=0, go to HALT instead, with misalign_err=1; pc is still loaded.
- sync_start_pulse is ignored in BOOT and RUN.
- BOOT: fetch_req_valid=0. Unconditionally go to RUN next cycle.
- RUN: fetch_req_valid=1, fetch_req_pc=pc.
  - pc is held stable while valid&&!ready.
  - On accept, pc <= pc+4, modulo 2^PC_WIDTH (wraps from all-ones-minus-3 to 0).
- RUN event priority, highest first:
  1. halt_req: go to HALT, pc unchanged.
  2. exception_valid:
     - If (exception_id & cfg_latched)!=0, pc <= trap_vector and stay in RUN.
     - Otherwise go to HALT with pc unchanged.
  3. redirect_valid: pc <= redirect_pc.
  4. Accept: pc <= pc+4.
- A lower-priority event in the same cycle is dropped. An accept coinciding with a redirect or trap is a squashed fetch; its response is discarded downstream.
- Redirect/trap target with [1:0]!=0: go to HALT, misalign_err=1, pc <= target.
- halt_req, redirect_valid and exception_valid are ignored outside RUN.
- HALT: fetch_req_valid=0. Wait for sync_start_pulse (restart path identical to IDLE).
- Reset (any state, including mid-handshake):
  - state=IDLE, pc=0, fetch_req_valid=0.
  - core_running=0, core_halted=0, misalign_err=0, cfg_latched=0.

## Timing
- Start latency:
  - Pulse at cycle T: state=BOOT at T+1.
  - First fetch_req_valid=1 with fetch_req_pc=start_pc at T+2; core_running=1 at T+2.
- An accept at cycle N shows pc+4 on fetch_req_pc at N+1. Back-to-back accepts give one new PC per cycle.
- A redirect, trap or halt at cycle N takes effect at N+1:
  - New PC on fetch_req_pc, or fetch_req_valid=0 for halt.
  - core_halted=1 at N+1.
- No combinational path from any input to any output.

## Test plan
- Boot: reset 3 cycles. Pulse with start_pc=0x0000_1000 and ready=1. Expect valid=1 at T+2, then PCs 0x1000, 0x1004, 0x1008 on consecutive cycles.
- Backpressure: ready=0 for 4 cycles in RUN. Expect pc held at 0x1008 and valid held at 1. Raise ready; expect 0x100C next cycle.
- Priority: in one cycle, redirect_pc=0x2000, exception_id=4'b0010 with cfg=4'b0010, trap_vector=0x0100, and accept. Expect pc=0x0100. Repeat with cfg=0: expect HALT, valid=0, core_halted=1.
- Misalign: start_pc=0x1002. Expect HALT, misalign_err=1, valid never asserted. Then restart with 0x1000: expect misalign_err=0 and normal fetch.
- Wrap: redirect to 0xFFFF_FFFC, accept twice. Expect 0xFFFF_FFFC, then 0x0000_0000.
- Reset mid-run: assert rst_n=0 while valid=1 and ready=0. Expect valid=0, state IDLE, all outputs zero next cycle; a start pulse during RUN is ignored.
